// File: rtl/torus_step_sequencer.sv
// Step controller for the Cannon-style N-step torus multiply: load, then
// N x (fire cells, wait for EOM low then high, rotate operands), then done.
module torus_step_sequencer #(
  parameter int N      = 4,
  parameter int STEP_W = 3,
  parameter int TMO    = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              EOM_ALL,
  output logic              STM,
  output logic              LOAD,
  output logic              CLR_ACC,
  output logic              SHIFT_A,
  output logic              SHIFT_B,
  output logic [STEP_W-1:0] STEP,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FIRE    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_SHIFT   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N - 1);
  localparam logic [7:0]        TMO_LAST  = 8'(TMO - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                stm_q, load_q, shift_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          step_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: state_d = S_FIRE;
      S_FIRE: begin
        state_d = S_WAIT_LO;
        cnt_d   = '0;
      end
      S_WAIT_LO: begin
        // Cells must first acknowledge STM by dropping EOM.
        if (!EOM_ALL) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_WAIT_HI: begin
        if (EOM_ALL) begin
          state_d = (step_q == STEP_LAST) ? S_FINISH : S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_SHIFT: begin
        step_d  = step_q + 1'b1;
        state_d = S_FIRE;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stm_q   <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stm_q   <= (state_d == S_FIRE);
      load_q  <= (state_d == S_LOAD);
      shift_q <= (state_d == S_SHIFT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
    end
  end

  assign STM     = stm_q;
  assign LOAD    = load_q;
  assign CLR_ACC = load_q;
  assign SHIFT_A = shift_q;
  assign SHIFT_B = shift_q;
  assign STEP    = step_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_torus_step_sequencer.sv
// Bench for torus_step_sequencer: nominal vector table, corner sequences and
// a randomized run checked against a procedural run-level model.
module tb_torus_step_sequencer;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int C   = 800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0, eom_s = 1'b1;
  logic start2_s = 1'b0, eom2_s = 1'b1;

  logic stm, load, clr, sha, shb, busy, done, err;
  logic [2:0] step;
  logic stm2, load2, clr2, sha2, shb2, busy2, done2, err2;
  logic [0:0] step2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  torus_step_sequencer #(.N(N), .STEP_W(3), .TMO(TMO)) dut (
    .CLK(clk), .RST(rst), .START(start_s), .EOM_ALL(eom_s),
    .STM(stm), .LOAD(load), .CLR_ACC(clr), .SHIFT_A(sha), .SHIFT_B(shb),
    .STEP(step), .BUSY(busy), .DONE(done), .ERR(err)
  );

  torus_step_sequencer #(.N(2), .STEP_W(1), .TMO(TMO)) dut2 (
    .CLK(clk), .RST(rst), .START(start2_s), .EOM_ALL(eom2_s),
    .STM(stm2), .LOAD(load2), .CLR_ACC(clr2), .SHIFT_A(sha2), .SHIFT_B(shb2),
    .STEP(step2), .BUSY(busy2), .DONE(done2), .ERR(err2)
  );

  typedef struct {
    logic        start;
    logic        eom;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[28];
  logic        st_v[C];
  logic        eo_v[C];
  logic [31:0] ex_v[C];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit s, input bit l, input bit cl, input bit sh,
                                     input bit b, input bit d, input bit e, input int st);
    logic [2:0] st3;
    st3 = 3'(st);
    return 32'({s, l, cl, sh, sh, b, d, e, st3});
  endfunction

  function automatic logic [31:0] obs();
    return 32'({stm, load, clr, sha, shb, busy, done, err, step});
  endfunction

  // One clock cycle: inputs change just after the edge, outputs sampled mid-cycle.
  task automatic cyc(input logic s, input logic e, input logic s2 = 1'b0, input logic e2 = 1'b1);
    @(posedge clk);
    #1;
    start_s  = s;
    eom_s    = e;
    start2_s = s2;
    eom2_s   = e2;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_s = 1'b0; eom_s = 1'b1; start2_s = 1'b0; eom2_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void put(input int c, input logic [31:0] v);
    if (c < C) ex_v[c] = v;
  endfunction

  // Run-level reference: walk through a whole job as a structured program.
  function automatic void build_exp();
    int c = 0;
    int st = 0;
    bit e = 1'b0;
    while (c < C) begin
      put(c, mk(0, 0, 0, 0, 0, 0, e, st));
      if (!st_v[c]) begin
        c++;
        continue;
      end
      c++;
      e  = 1'b0;
      st = 0;
      put(c, mk(0, 1, 1, 0, 1, 0, 0, 0));
      c++;
      for (int s = 0; s < N; s++) begin
        int cnt;
        bit seen;
        st = s;
        put(c, mk(1, 0, 0, 0, 1, 0, 0, st));
        c++;
        cnt = 0; seen = 1'b0;
        while (c < C && !seen && cnt < TMO) begin
          put(c, mk(0, 0, 0, 0, 1, 0, 0, st));
          if (!eo_v[c]) seen = 1'b1; else cnt++;
          c++;
        end
        if (!seen) begin
          if (cnt < TMO) return;
          e = 1'b1;
          break;
        end
        cnt = 0; seen = 1'b0;
        while (c < C && !seen && cnt < TMO) begin
          put(c, mk(0, 0, 0, 0, 1, 0, 0, st));
          if (eo_v[c]) seen = 1'b1; else cnt++;
          c++;
        end
        if (!seen) begin
          if (cnt < TMO) return;
          e = 1'b1;
          break;
        end
        if (s < N - 1) begin
          put(c, mk(0, 0, 0, 1, 1, 0, 0, st));
          c++;
        end
      end
      put(c, mk(0, 0, 0, 0, 1, 1, e, st));
      c++;
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, lo2, cnt, dones, stm_cnt, last_done, sh_cnt, done_c, rise_c;
    logic prev_e2;

    // Nominal N=4 job with a 3-cycle cell, cycle 0 = START presented.
    for (int c = 0; c < 28; c++) begin
      int st;
      bit lo_w;
      lo_w = (c >= 3) && (c <= 23) && (((c - 3) % 6) < 3);
      st = (c < 8) ? 0 : (c < 14) ? 1 : (c < 20) ? 2 : 3;
      tbl[c].start = (c == 0);
      tbl[c].eom   = !lo_w;
      tbl[c].exp   = mk(c == 2 || c == 8 || c == 14 || c == 20, c == 1, c == 1,
                        c == 7 || c == 13 || c == 19, c >= 1 && c <= 25, c == 25, 0, st);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", obs(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 28; c++) begin
      cyc(tbl[c].start, tbl[c].eom);
      chk($sformatf("nominal c%0d", c), obs(), tbl[c].exp);
    end

    // Reset asserted while in WAIT_HI at step 2.
    lo = 0;
    for (int c = 0; c <= 17; c++) begin
      cyc(c == 0, lo == 0);
      if (lo > 0) lo--;
      if (stm) lo = 3;
    end
    chk("pre-reset wait_hi step2", obs(), mk(0, 0, 0, 0, 1, 0, 0, 2));
    #1 rst = 1'b1;
    #1 chk("async reset outputs", obs(), 32'd0);
    cyc(0, 1);
    chk("reset held", obs(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 1);
      if (done || busy) cnt++;
    end
    chk("no done/busy after reset", cnt, 0);

    // Stalled cells: EOM never drops.
    for (int c = 0; c <= 19; c++) begin
      cyc(c == 0, 1);
      if (c == 17) chk("stall last wait_lo", obs(), mk(0, 0, 0, 0, 1, 0, 0, 0));
      if (c == 18) chk("stall finish", obs(), mk(0, 0, 0, 0, 1, 1, 1, 0));
      if (c == 19) chk("stall idle err", obs(), mk(0, 0, 0, 0, 0, 0, 1, 0));
    end

    // Stuck busy: EOM drops and stays low; then restart clears ERR.
    for (int c = 0; c <= 22; c++) begin
      cyc(c == 0 || c == 21, c < 3);
      if (c == 18) chk("stuck last wait_hi", obs(), mk(0, 0, 0, 0, 1, 0, 0, 0));
      if (c == 19) chk("stuck finish", obs(), mk(0, 0, 0, 0, 1, 1, 1, 0));
      if (c == 20) chk("stuck idle err", obs(), mk(0, 0, 0, 0, 0, 0, 1, 0));
      if (c == 21) chk("err held in idle", obs(), mk(0, 0, 0, 0, 0, 0, 1, 0));
      if (c == 22) chk("restart load clears err", obs(), mk(0, 1, 1, 0, 1, 0, 0, 0));
    end
    do_reset();

    // START held high: back-to-back jobs.
    lo = 0; dones = 0; stm_cnt = 0; last_done = -1;
    for (int c = 0; c <= 77; c++) begin
      cyc(1, lo == 0);
      if (lo > 0) lo--;
      if (stm) begin
        lo = 3;
        stm_cnt++;
      end
      if (done) begin
        chk($sformatf("stm per run %0d", dones), stm_cnt, N);
        if (last_done >= 0) chk("back-to-back spacing", c - last_done, 26);
        last_done = c;
        dones++;
        stm_cnt = 0;
      end
    end
    chk("held start run count", dones, 3);
    cyc(0, 1);
    chk("idle after held start", 32'(busy), 32'd0);

    // N=2 instance with a 7-cycle cell.
    lo2 = 0; stm_cnt = 0; sh_cnt = 0; done_c = -1; rise_c = -1; cnt = 0;
    prev_e2 = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      cyc(0, 1, c == 0, lo2 == 0);
      if (!prev_e2 && eom2_s) rise_c = c;
      prev_e2 = eom2_s;
      if (lo2 > 0) lo2--;
      if (stm2) begin
        lo2 = 7;
        stm_cnt++;
      end
      if (sha2) sh_cnt++;
      if (sha2 !== shb2 || clr2 !== load2) cnt++;
      if (done2) begin
        done_c = c;
        chk("n2 step at done", 32'(step2), 32'd1);
      end
    end
    chk("n2 stm pulses", stm_cnt, 2);
    chk("n2 shift pulses", sh_cnt, 1);
    chk("n2 done after eom rise", done_c, rise_c + 1);
    chk("n2 strobe pairing", cnt, 0);
    chk("n2 err/busy end", 32'({err2, busy2}), 32'd0);

    // Randomized inputs against the run-level model.
    do_reset();
    begin
      int c = 0;
      while (c < C) begin
        int len;
        logic v;
        len = $urandom_range(1, 20);
        v = 1'($urandom_range(0, 1));
        for (int k = 0; k < len && c < C; k++) begin
          eo_v[c] = v;
          st_v[c] = ($urandom_range(0, 3) == 0);
          c++;
        end
      end
    end
    build_exp();
    for (int c = 0; c < C; c++) begin
      cyc(st_v[c], eo_v[c]);
      chk($sformatf("random c%0d", c), obs(), ex_v[c]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/torus_step_sequencer.md
Name: torus_step_sequencer

Overview:
- Top-level step controller for the matrix-multiplication torus.
- Runs Cannon-style N-step multiplication: loads the pre-skewed operands, clears the accumulators, then fires each cell controller once per step and rotates A left / B up between steps.
- Sits upstream of the per-cell multiply controllers. It drives their shared start strobe STM and consumes the AND-reduced end-of-multiply level from all cells.
- Reports completion or timeout to the host.

Parameters:
- N, 4, torus dimension; number of multiply steps (2..255).
- STEP_W, 3, width of STEP output; must satisfy 2^STEP_W >= N.
- TMO, 15, max cycles allowed in each wait state before timeout (1..255).

Ports:
- CLK  in  1  master clock, rising edge.
- RST  in  1  master reset, asynchronous, active-high.
- START  in  1  host start request, level-sampled in IDLE.
- EOM_ALL  in  1  AND of all cell EOM outputs; high = every cell idle.
- STM  out  1  start-multiply strobe to all cell controllers.
- LOAD  out  1  load initial (pre-skewed) A/B operands into the torus registers.
- CLR_ACC  out  1  clear all cell accumulators.
- SHIFT_A  out  1  rotate A operands one position left (row wrap).
- SHIFT_B  out  1  rotate B operands one position up (column wrap).
- STEP  out  STEP_W  index of the current step, 0..N-1.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky timeout flag.

Behaviour:
- Moore FSM with states IDLE, LOAD, FIRE, WAIT_LO, WAIT_HI, SHIFT, FINISH. All outputs are decoded from registered state/counters only.
- Reset (async, RST=1): state=IDLE; STEP=0; wait counter=0; ERR=0; all strobes and BUSY/DONE = 0.
- IDLE: START=1 -> LOAD, clear ERR and STEP. START=0 -> stay. START is ignored in any other state.
- LOAD (1 cycle): LOAD=1, CLR_ACC=1 -> FIRE.
- FIRE (1 cycle): STM=1; wait counter cleared -> WAIT_LO.
- WAIT_LO: EOM_ALL=0 -> WAIT_HI, counter cleared. Otherwise counter++. Counter reaching TMO -> ERR=1, go to FINISH.
- WAIT_HI: EOM_ALL=1 -> SHIFT if STEP<N-1, else FINISH. Otherwise counter++. Counter reaching TMO -> ERR=1, go to FINISH.
- SHIFT (1 cycle): SHIFT_A=SHIFT_B=1; STEP increments at end of cycle -> FIRE.
- FINISH (1 cycle): DONE=1 -> IDLE. ERR holds until the next accepted START or RST.
- BUSY=1 in LOAD..FINISH inclusive.
- STEP never wraps past N-1. The last step always exits via FINISH with no SHIFT.
- At most one of LOAD/STM/SHIFT_A/DONE is high in any cycle. CLR_ACC only with LOAD. SHIFT_A and SHIFT_B are always equal.
- A cell controller with 3-cycle busy time (EOM low for 3 cycles, starting the cycle after STM) gives per-step timing: FIRE, WAIT_LO x1, WAIT_HI x3, then SHIFT/FINISH. That is 6 cycles per non-final step.
- RST mid-operation aborts immediately to IDLE with no DONE pulse. Torus data contents are not the sequencer's concern.
- EOM_ALL glitches while in FIRE are ignored, since EOM_ALL is sampled only in WAIT states.

Test Plan:
- Reset: assert RST mid-run (in WAIT_HI, STEP=2) -> next sampled values: all outputs 0, STEP=0, BUSY=0; no DONE thereafter.
- Nominal N=4 with a 3-cycle cell model: START high in cycle 0 -> LOAD+CLR_ACC at cycle 1; STM at cycles 2, 8, 14, 20; SHIFT_A/B at 7, 13, 19; STEP values 0, 1, 2, 3; DONE at 25; BUSY cycles 1..25; ERR=0.
- Stalled cells: EOM_ALL held high after STM, TMO=15 -> 15 cycles in WAIT_LO, then ERR=1, DONE pulse, IDLE; STEP unchanged (0).
- Stuck busy: EOM_ALL drops and never rises -> ERR=1 after TMO cycles in WAIT_HI; next START clears ERR in the LOAD cycle.
- START held high continuously -> runs back-to-back, each starting one cycle after DONE; START pulses during BUSY have no effect (STM count per run = N exactly).
- N=2, slow cell (EOM low 7 cycles) -> exactly 1 SHIFT and 2 STM pulses; DONE one cycle after EOM_ALL returns high on the second step.
